inert_cmd_seq: RTL and testbench
================================

// Module: inert_cmd_seq
// PURPOSE
// - Command sequencer directly upstream of the SPI monarch in the inertial interface.
// - After reset, waits for the gyro to power up, then writes three configuration registers.
// - Then, on each synchronized INT, reads yaw-rate low and high bytes and presents a 16-bit
//   yaw rate with a one-cycle valid pulse to the heading logic.
// PARAMETERS
// - INIT_WAIT_BITS  16  power-up timer width; first SPI write when timer reaches all ones.
//   Use 4 in simulation.
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   reset, asynchronous, active-low
// - INT        in   1   gyro data-ready interrupt, asynchronous, active-high level
// - done       in   1   SPI transaction complete; high until next wrt is accepted
// - rd_data    in   16  SPI read-back word; [7:0] is register data
// - wrt        out  1   one-cycle pulse: start SPI transaction with cmd
// - cmd        out  16  SPI command word: [15]=R/nW, [14:8]=addr, [7:0]=write data
// - yaw_rt     out  16  signed yaw rate {YAWH,YAWL}
// - vld        out  1   one-cycle pulse, coincident with yaw_rt update
// - init_done  out  1   high once all configuration writes have completed
// BEHAVIOUR
// - Reset values: wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, init_done=0;
//   state=INIT_WAIT, timer=0.
// - All outputs are registered. wrt is high for exactly one clk per transaction.
// - cmd changes only on the cycle wrt is asserted. It holds until the next wrt.
// - Completion is the rising edge of done (done_rise = done & ~done_q). Level done is never
//   used; this keeps a stale high done from the previous transaction out of the decision.
// - INT passes through a 2-flop synchronizer (reset 0). INT is treated as level.
// - FSM states and transitions:
//   INIT_WAIT: timer increments each clk. At all-ones: wrt, cmd=INIT1_CMD -> INIT1.
//   INIT1: on done_rise, wrt, cmd=INIT2_CMD -> INIT2.
//   INIT2: on done_rise, wrt, cmd=INIT3_CMD -> INIT3.
//   INIT3: on done_rise, init_done<=1 -> WAIT_INT.
//   WAIT_INT: when INT_sync=1, wrt, cmd=RD_YAWL_CMD -> RD_YAWL.
//   RD_YAWL: on done_rise, yawL<=rd_data[7:0], wrt, cmd=RD_YAWH_CMD -> RD_YAWH.
//   RD_YAWH: on done_rise, yaw_rt<={rd_data[7:0],yawL}, vld<=1 -> WAIT_INT.
//   default: -> INIT_WAIT.
// - Latency: vld fires 1 clk after the done_rise of the YAWH read. INT_sync to first wrt
//   is 1 clk.
// - If INT is still high on return to WAIT_INT, the next read pair starts immediately.
//   The bench must not see back-to-back vld closer than two SPI transactions.
// - INT asserted before init_done is ignored and not queued; it is sampled only in WAIT_INT.
// - Timer saturates; it stops once INIT_WAIT is left.
// - Async reset mid-transaction aborts to INIT_WAIT with all outputs at reset values.
//   The SPI monarch shares rst_n. The full power-up wait and config sequence repeat.
// - init_done is sticky; it clears only on rst_n.
// - yaw_rt holds its value between vld pulses. A half-updated yaw_rt is never visible.
// STRUCTURE
// - Package inert_pkg:
//   - state enum inert_state_t
//   - INIT1_CMD=16'h0D02 (INT cfg)
//   - INIT2_CMD=16'h1160 (gyro ODR/range)
//   - INIT3_CMD=16'h1440 (rounding)
//   - RD_YAWL_CMD=16'hA600
//   - RD_YAWH_CMD=16'hA700
// - Sub-module inert_int_sync: 2-flop synchronizer plus done rising-edge detector.
//   Everything else is inline.
// TESTING
// - Init sequence: INIT_WAIT_BITS=4, SPI model returns done 20 clk after wrt.
//   Expect wrt at clk 15; cmd sequence 0D02,1160,1440; init_done high after the third
//   done_rise; no other wrt.
// - Yaw read: after init, INT=1 for 3 clk; model returns A6->8'h34, A7->8'h12.
//   Expect cmds A600 then A700; vld once with yaw_rt=16'h1234.
// - Negative rate: model returns L=8'h00, H=8'h80. Expect yaw_rt=16'h8000; vld is exactly
//   1 clk.
// - Stale done: hold done high continuously after a transaction, then pulse INT.
//   Expect no progress past RD_YAWL until done falls and rises again.
// - Early INT: INT=1 during INIT_WAIT, low before init_done.
//   Expect no A600 cmd until a new INT in WAIT_INT.
// - Reset mid-read: assert rst_n=0 between A600 and A700.
//   Expect all outputs 0 immediately; after release, the full init sequence repeats
//   before any read.

Source files
------------

// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - states and SPI command words for the inertial command sequencer
package inert_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    INIT1     = 3'd1,
    INIT2     = 3'd2,
    INIT3     = 3'd3,
    WAIT_INT  = 3'd4,
    RD_YAWL   = 3'd5,
    RD_YAWH   = 3'd6
  } inert_state_t;

  // Command word: [15]=R/nW, [14:8]=register address, [7:0]=write data
  localparam logic [15:0] INIT1_CMD   = 16'h0D02;
  localparam logic [15:0] INIT2_CMD   = 16'h1160;
  localparam logic [15:0] INIT3_CMD   = 16'h1440;
  localparam logic [15:0] RD_YAWL_CMD = 16'hA600;
  localparam logic [15:0] RD_YAWH_CMD = 16'hA700;

endpackage

// File: rtl/inert_int_sync.sv
// rtl/inert_int_sync.sv - INT two-flop synchronizer and done rising-edge detector
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic int_async,
  input  logic done,
  output logic int_sync,
  output logic done_rise
);

  logic int_meta;
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      int_meta <= int_async;
      int_sync <= int_meta;
      done_q   <= done;
    end
  end

  // A done left high from the previous transaction never produces a rise.
  assign done_rise = done & ~done_q;

endmodule

// File: rtl/inert_cmd_seq.sv
// rtl/inert_cmd_seq.sv - gyro power-up config writes, then yaw-rate read pair per INT
module inert_cmd_seq
  import inert_pkg::*;
#(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  inert_state_t              state, nxt_state;
  logic [INIT_WAIT_BITS-1:0] timer;
  logic [7:0]                yaw_l, nxt_yaw_l;
  logic                      nxt_wrt, nxt_vld, nxt_init_done;
  logic [15:0]               nxt_cmd, nxt_yaw_rt;
  logic                      int_sync, done_rise;
  logic                      timer_full;
  logic                      unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign timer_full   = &timer;

  inert_int_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_async (INT),
    .done      (done),
    .int_sync  (int_sync),
    .done_rise (done_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_WAIT;
      timer     <= '0;
      yaw_l     <= 8'h00;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= nxt_state;
      yaw_l     <= nxt_yaw_l;
      wrt       <= nxt_wrt;
      cmd       <= nxt_cmd;
      yaw_rt    <= nxt_yaw_rt;
      vld       <= nxt_vld;
      init_done <= nxt_init_done;
      // Saturating power-up timer; frozen once the config sequence starts.
      if (state == INIT_WAIT && !timer_full)
        timer <= timer + {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_yaw_l     = yaw_l;
    nxt_wrt       = 1'b0;
    nxt_cmd       = cmd;
    nxt_yaw_rt    = yaw_rt;
    nxt_vld       = 1'b0;
    nxt_init_done = init_done;
    case (state)
      INIT_WAIT: if (timer_full) begin
        nxt_wrt   = 1'b1;
        nxt_cmd   = INIT1_CMD;
        nxt_state = INIT1;
      end
      INIT1: if (done_rise) begin
        nxt_wrt   = 1'b1;
        nxt_cmd   = INIT2_CMD;
        nxt_state = INIT2;
      end
      INIT2: if (done_rise) begin
        nxt_wrt   = 1'b1;
        nxt_cmd   = INIT3_CMD;
        nxt_state = INIT3;
      end
      INIT3: if (done_rise) begin
        nxt_init_done = 1'b1;
        nxt_state     = WAIT_INT;
      end
      WAIT_INT: if (int_sync) begin
        nxt_wrt   = 1'b1;
        nxt_cmd   = RD_YAWL_CMD;
        nxt_state = RD_YAWL;
      end
      RD_YAWL: if (done_rise) begin
        nxt_yaw_l = rd_data[7:0];
        nxt_wrt   = 1'b1;
        nxt_cmd   = RD_YAWH_CMD;
        nxt_state = RD_YAWH;
      end
      // Both bytes land in yaw_rt together so a torn value is never visible.
      RD_YAWH: if (done_rise) begin
        nxt_yaw_rt = {rd_data[7:0], yaw_l};
        nxt_vld    = 1'b1;
        nxt_state  = WAIT_INT;
      end
      default: nxt_state = INIT_WAIT;
    endcase
  end

endmodule

// File: tb/tb_inert_cmd_seq.sv
// tb/tb_inert_cmd_seq.sv - directed bench for inert_cmd_seq with a 20-clk SPI monarch model
module tb_inert_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  logic [15:0] log_q[$];
  int          cyc = 0;
  int          vld_count = 0, vld_double = 0, last_vld_cyc = 0, prev_vld_cyc = 0;
  logic        vld_prev = 1'b0;
  logic        stall = 1'b0, pending = 1'b0, busy = 1'b0;
  int          cnt = 0;
  logic [15:0] cur = 16'h0000;
  logic [7:0]  yawl_val = 8'h00, yawh_val = 8'h00;

  always #5 clk = ~clk;

  inert_cmd_seq #(.INIT_WAIT_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  always @(posedge clk) cyc++;

  // SPI monarch model: done drops on an accepted wrt and rises 20 clk later with data.
  always @(negedge clk) begin
    if (!rst_n) begin
      done = 1'b0; busy = 1'b0; pending = 1'b0; vld_prev = 1'b0;
    end else begin
      if (wrt) begin
        log_q.push_back(cmd);
        cur = cmd;
        pending = 1'b1;
      end
      if (pending && !stall) begin
        done = 1'b0; cnt = 20; busy = 1'b1; pending = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          busy = 1'b0;
          rd_data = (cur[14:8] == 7'h26) ? {8'hEE, yawl_val} :
                    (cur[14:8] == 7'h27) ? {8'hEE, yawh_val} : 16'hEEEE;
        end
      end
      if (vld) begin
        vld_count++;
        if (vld_prev) vld_double++;
        prev_vld_cyc = last_vld_cyc;
        last_vld_cyc = cyc;
      end
      vld_prev = vld;
    end
  end

  task automatic pulse_int(input int n);
    @(negedge clk); INT = 1'b1;
    repeat (n) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic wait_vld(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (vld_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_log(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  // Release reset at a negedge and count rising edges until wrt is first seen.
  task automatic start_after_reset(output int edges);
    @(negedge clk); rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (wrt) break;
    end
  endtask

  task automatic apply_reset;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 log_q.delete();
  endtask

  task automatic check_init_log(input string tag);
    checks++;
    if (log_q.size() !== 3) begin
      errors++; $display("FAIL %s_count: got %0d want 3", tag, log_q.size());
    end else begin
      checks++;
      if (log_q[0] !== 16'h0D02 || log_q[1] !== 16'h1160 || log_q[2] !== 16'h1440) begin
        errors++;
        $display("FAIL %s_cmds: got %h %h %h want 0d02 1160 1440", tag, log_q[0], log_q[1], log_q[2]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL rst_wrt: got %b want 0", wrt); end
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL rst_cmd: got %h want 0000", cmd); end
    checks++; if (yaw_rt !== 16'h0000) begin errors++; $display("FAIL rst_yaw: got %h want 0000", yaw_rt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", vld); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    repeat (3) @(negedge clk);
    #1 log_q.delete();
  endtask

  task automatic test_init;
    int edges; bit ok;
    start_after_reset(edges);
    // Timer reaches 15 after 15 edges; wrt is registered on the 16th edge (index 15).
    checks++; if (edges !== 16) begin errors++; $display("FAIL init_wrt_edge: got %0d want 16", edges); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b want 0", init_done); end
    wait_init(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_timeout: got %b want 1", ok); end
    repeat (40) @(negedge clk);
    #1 check_init_log("init");
    checks++; if (cmd !== 16'h1440) begin errors++; $display("FAIL init_cmd_hold: got %h want 1440", cmd); end
  endtask

  task automatic test_yaw_read;
    int n0, v0; bit ok;
    n0 = log_q.size(); v0 = vld_count;
    yawl_val = 8'h34; yawh_val = 8'h12;
    pulse_int(3);
    wait_vld(v0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL yaw_timeout: got %b want 1", ok); end
    checks++; if (yaw_rt !== 16'h1234) begin errors++; $display("FAIL yaw_value: got %h want 1234", yaw_rt); end
    repeat (60) @(negedge clk);
    #1;
    checks++; if (vld_count !== v0 + 1) begin errors++; $display("FAIL yaw_vld_count: got %0d want %0d", vld_count, v0 + 1); end
    checks++;
    if (log_q.size() !== n0 + 2) begin
      errors++; $display("FAIL yaw_cmd_count: got %0d want %0d", log_q.size(), n0 + 2);
    end else begin
      checks++;
      if (log_q[n0] !== 16'hA600 || log_q[n0+1] !== 16'hA700) begin
        errors++; $display("FAIL yaw_cmds: got %h %h want a600 a700", log_q[n0], log_q[n0+1]);
      end
    end
    checks++; if (yaw_rt !== 16'h1234) begin errors++; $display("FAIL yaw_hold: got %h want 1234", yaw_rt); end
  endtask

  task automatic test_negative;
    int v0; bit ok;
    v0 = vld_count;
    yawl_val = 8'h00; yawh_val = 8'h80;
    pulse_int(3);
    wait_vld(v0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL neg_timeout: got %b want 1", ok); end
    checks++; if (yaw_rt !== 16'h8000) begin errors++; $display("FAIL neg_value: got %h want 8000", yaw_rt); end
    @(negedge clk); #1;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL neg_vld_width: got %b want 0", vld); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int v0; bit ok;
    v0 = vld_count;
    yawl_val = 8'hCD; yawh_val = 8'hAB;
    @(negedge clk); INT = 1'b1;
    wait_vld(v0 + 2, ok);
    INT = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got %b want 1", ok); end
    checks++;
    if (last_vld_cyc - prev_vld_cyc < 40) begin
      errors++; $display("FAIL b2b_spacing: got %0d want >=40", last_vld_cyc - prev_vld_cyc);
    end
    checks++; if (yaw_rt !== 16'hABCD) begin errors++; $display("FAIL b2b_value: got %h want abcd", yaw_rt); end
    checks++; if (vld_double !== 0) begin errors++; $display("FAIL b2b_vld_width: got %0d want 0", vld_double); end
    repeat (120) @(negedge clk);
  endtask

  task automatic test_stale_done;
    int n0, v0; bit ok;
    n0 = log_q.size(); v0 = vld_count;
    yawl_val = 8'h56; yawh_val = 8'h78;
    stall = 1'b1;
    pulse_int(3);
    repeat (80) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() !== n0 + 1) begin
      errors++; $display("FAIL stale_cmd_count: got %0d want %0d", log_q.size(), n0 + 1);
    end else begin
      checks++;
      if (log_q[n0] !== 16'hA600) begin errors++; $display("FAIL stale_cmd: got %h want a600", log_q[n0]); end
    end
    checks++; if (vld_count !== v0) begin errors++; $display("FAIL stale_vld: got %0d want %0d", vld_count, v0); end
    stall = 1'b0;
    wait_vld(v0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stale_timeout: got %b want 1", ok); end
    checks++; if (yaw_rt !== 16'h7856) begin errors++; $display("FAIL stale_value: got %h want 7856", yaw_rt); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_early_int;
    int edges; bit ok;
    apply_reset();
    INT = 1'b1;
    start_after_reset(edges);
    INT = 1'b0;
    checks++; if (edges !== 16) begin errors++; $display("FAIL early_wrt_edge: got %0d want 16", edges); end
    wait_init(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL early_init_timeout: got %b want 1", ok); end
    repeat (60) @(negedge clk);
    #1 check_init_log("early");
    pulse_int(3);
    wait_log(4, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL early_read_timeout: got %b want 1", ok);
    end else begin
      checks++;
      if (log_q[3] !== 16'hA600) begin errors++; $display("FAIL early_read_cmd: got %h want a600", log_q[3]); end
    end
  endtask

  task automatic test_reset_mid_read;
    int edges; bit ok;
    // A read pair is already in flight from the early-INT test; reset before A700.
    repeat (5) @(negedge clk);
    #1;
    checks++; if (cmd !== 16'hA600) begin errors++; $display("FAIL mid_pre_cmd: got %h want a600", cmd); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL mid_cmd: got %h want 0000", cmd); end
    checks++; if (yaw_rt !== 16'h0000) begin errors++; $display("FAIL mid_yaw: got %h want 0000", yaw_rt); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b want 0", init_done); end
    checks++; if ({wrt, vld} !== 2'b00) begin errors++; $display("FAIL mid_pulses: got %b want 00", {wrt, vld}); end
    repeat (3) @(negedge clk);
    #1 log_q.delete();
    start_after_reset(edges);
    checks++; if (edges !== 16) begin errors++; $display("FAIL mid_wrt_edge: got %0d want 16", edges); end
    wait_init(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_init_timeout: got %b want 1", ok); end
    repeat (40) @(negedge clk);
    #1 check_init_log("mid");
  endtask

  initial begin
    test_reset();
    test_init();
    test_yaw_read();
    test_negative();
    test_back_to_back();
    test_stale_done();
    test_early_int();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
